bitmap_2d_scanner: RTL

- Sequential consumer for the 2D first-set mapping in the Image Resizer.
- Accepts a DATA_Y_W x DATA_X_W bitmap through a valid/ready load port and keeps it in a working register.
- Each cycle, selects the first set bit (row-priority Y from 0 upward, then X from LSB upward) and emits its binary (X, Y) coordinate on a valid/ready stream.
- Clears each bit once its coordinate is accepted, and repeats until the bitmap is empty.

---
 rtl/bitmap_2d_scanner.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/bitmap_2d_scanner.sv
// bitmap_2d_scanner: loads a DATA_Y_W x DATA_X_W bitmap, then streams the
// (X, Y) coordinate of each set bit in row-major order (row 0 first, LSB first
// within a row), clearing each bit as its coordinate is accepted.
// Optional build macro BITMAP_2D_SCANNER_ABORT_EN adds an Abort input that
// discards the bitmap being scanned.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high. A producer holding valid keeps its payload stable until that
// edge, and ready never depends on the partner's valid.
module bitmap_2d_scanner #(
  parameter int DATA_X_W = 7,
  parameter int DATA_Y_W = 5,
  parameter int X_IDX_W  = (DATA_X_W > 1) ? $clog2(DATA_X_W) : 1,
  parameter int Y_IDX_W  = (DATA_Y_W > 1) ? $clog2(DATA_Y_W) : 1,
  parameter int CNT_W    = $clog2(DATA_X_W*DATA_Y_W+1)
) (
  input  logic                Clk,
  input  logic                Rst_n,
  input  logic [DATA_X_W-1:0] MaskIn [DATA_Y_W-1:0],
  input  logic                MaskValid,
  output logic                MaskReady,
  output logic [X_IDX_W-1:0]  CoordX,
  output logic [Y_IDX_W-1:0]  CoordY,
  output logic [CNT_W-1:0]    CoordCnt,
  output logic                CoordLast,
  output logic                CoordValid,
  input  logic                CoordReady,
`ifdef BITMAP_2D_SCANNER_ABORT_EN
  input  logic                Abort,
`endif
  output logic                Done
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } state_t;

  state_t                             r_state;
  state_t                             w_state_nxt;
  logic [DATA_Y_W-1:0][DATA_X_W-1:0]  r_mask;
  logic [DATA_Y_W-1:0][DATA_X_W-1:0]  w_mask_nxt;
  logic [DATA_Y_W-1:0][DATA_X_W-1:0]  w_mask_in;
  logic [DATA_Y_W-1:0][DATA_X_W-1:0]  w_mask_clr;
  logic [CNT_W-1:0]                   r_cnt;
  logic [CNT_W-1:0]                   w_cnt_nxt;
  logic                               r_done;
  logic                               w_done_nxt;
  logic                               w_found;
  logic [X_IDX_W-1:0]                 w_sel_x;
  logic [Y_IDX_W-1:0]                 w_sel_y;
  logic                               w_last;

  // Flatten the unpacked row array so it can be captured as one vector.
  always_comb begin
    for (int y = 0; y < DATA_Y_W; y++) begin
      w_mask_in[y] = MaskIn[y];
    end
  end

  // Pick the first set bit (lowest row, then lowest column) and build the
  // working mask with that bit removed.
  always_comb begin
    w_found    = 1'b0;
    w_sel_x    = '0;
    w_sel_y    = '0;
    w_mask_clr = r_mask;
    for (int y = 0; y < DATA_Y_W; y++) begin
      for (int x = 0; x < DATA_X_W; x++) begin
        if (!w_found && r_mask[y][x]) begin
          w_found          = 1'b1;
          w_sel_x          = X_IDX_W'(x);
          w_sel_y          = Y_IDX_W'(y);
          w_mask_clr[y][x] = 1'b0;
        end
      end
    end
  end

  // The current coordinate is the last one when nothing else remains.
  assign w_last = (w_mask_clr == '0);

  // Next-state logic: load in IDLE, consume coordinates in SCAN.
  always_comb begin
    w_state_nxt = r_state;
    w_mask_nxt  = r_mask;
    w_cnt_nxt   = r_cnt;
    w_done_nxt  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (MaskValid) begin
          w_mask_nxt = w_mask_in;
          w_cnt_nxt  = '0;
          if (w_mask_in != '0) begin
            w_state_nxt = ST_SCAN;
          end else begin
            // Empty bitmap: nothing to emit, report completion directly.
            w_done_nxt = 1'b1;
          end
        end
      end
      ST_SCAN: begin
        if (CoordReady) begin
          w_mask_nxt = w_mask_clr;
          w_cnt_nxt  = r_cnt + CNT_W'(1);
          if (w_last) begin
            w_state_nxt = ST_IDLE;
            w_done_nxt  = 1'b1;
          end
        end
`ifdef BITMAP_2D_SCANNER_ABORT_EN
        // Abort wins over any coincident transfer and suppresses Done.
        if (Abort) begin
          w_mask_nxt  = '0;
          w_cnt_nxt   = '0;
          w_state_nxt = ST_IDLE;
          w_done_nxt  = 1'b0;
        end
`endif
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State register; reset discards any partially scanned bitmap.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_state <= ST_IDLE;
      r_mask  <= '0;
      r_cnt   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_mask  <= w_mask_nxt;
      r_cnt   <= w_cnt_nxt;
      r_done  <= w_done_nxt;
    end
  end

  assign MaskReady  = (r_state == ST_IDLE);
  assign CoordValid = (r_state == ST_SCAN);
  assign CoordX     = w_sel_x;
  assign CoordY     = w_sel_y;
  assign CoordCnt   = r_cnt;
  assign CoordLast  = w_last;
  assign Done       = r_done;

endmodule
